// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes (common with the ALU controller),
// execute-unit FSM states and the default datapath width.
package alu_pkg;

    localparam int unsigned AluWidth = 32;

    typedef enum logic [3:0] {
        OpNop  = 4'd0,
        OpXor  = 4'd1,
        OpOr   = 4'd2,
        OpAnd  = 4'd3,
        OpNor  = 4'd4,
        OpSll  = 4'd5,
        OpSrl  = 4'd6,
        OpSlt  = 4'd7,
        OpAdd  = 4'd8,
        OpAddu = 4'd9,
        OpSub  = 4'd10,
        OpSubu = 4'd11,
        OpMult = 4'd12,
        OpDiv  = 4'd13
    } alu_op_t;

    typedef enum logic [1:0] {
        StIdle,
        StSingle,
        StIter,
        StFix
    } state_t;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative signed multiply / divide engine: one step per cycle for WIDTH cycles on magnitudes,
// sign fix-up applied combinationally on the final step. Divider present only with ALU_DIV_EN.
module alu_muldiv_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = AluWidth
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dbz
);
    localparam int unsigned CntW = $clog2(WIDTH);

    logic               run_q, run_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d, q_q, q_d, mcand_q, mcand_d;
    logic               neg_res_q, neg_res_d;
    logic [WIDTH-1:0]   abs_a, abs_b, step_acc, step_q;
    logic [WIDTH:0]     mul_part;
    logic [2*WIDTH-1:0] prod, prod_fix;

    assign abs_a = a[WIDTH-1] ? -a : a;
    assign abs_b = b[WIDTH-1] ? -b : b;

    // Right-shifting shift-add: {acc, q} holds partial product and remaining multiplier bits
    assign mul_part = q_q[0] ? ({1'b0, acc_q} + {1'b0, mcand_q}) : {1'b0, acc_q};
    assign prod     = {mul_part[WIDTH:1], mul_part[0], q_q[WIDTH-1:1]};
    assign prod_fix = neg_res_q ? -prod : prod;
    assign last     = run_q && (cnt_q == CntW'(WIDTH - 1));

`ifdef ALU_DIV_EN
    logic             div_q, div_d, neg_rem_q, neg_rem_d, bzero_q, bzero_d;
    logic [WIDTH:0]   shifted, diff;
    logic [WIDTH-1:0] quo;

    // Restoring division: {acc, q} shifts left, q collects quotient bits
    assign shifted = {acc_q, q_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, mcand_q};

    always_comb begin
        if (!div_q) begin
            step_acc = prod[2*WIDTH-1:WIDTH];
            step_q   = prod[WIDTH-1:0];
        end else if (!diff[WIDTH]) begin
            step_acc = diff[WIDTH-1:0];
            step_q   = {q_q[WIDTH-2:0], 1'b1};
        end else begin
            step_acc = shifted[WIDTH-1:0];
            step_q   = {q_q[WIDTH-2:0], 1'b0};
        end
    end

    // With b == 0 the remainder path naturally ends at |a|, so hi comes out as a
    assign quo = bzero_q ? '1 : (neg_res_q ? -step_q : step_q);
    assign hi  = div_q ? (neg_rem_q ? -step_acc : step_acc) : prod_fix[2*WIDTH-1:WIDTH];
    assign lo  = div_q ? quo : prod_fix[WIDTH-1:0];
    assign dbz = div_q && bzero_q;

    always_comb begin
        div_d     = div_q;
        neg_rem_d = neg_rem_q;
        bzero_d   = bzero_q;
        if (start) begin
            div_d     = is_div;
            neg_rem_d = a[WIDTH-1];
            bzero_d   = (b == '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            bzero_q   <= 1'b0;
        end else begin
            div_q     <= div_d;
            neg_rem_q <= neg_rem_d;
            bzero_q   <= bzero_d;
        end
    end
`else
    logic unused_div;
    assign unused_div = is_div;
    assign step_acc   = prod[2*WIDTH-1:WIDTH];
    assign step_q     = prod[WIDTH-1:0];
    assign hi         = prod_fix[2*WIDTH-1:WIDTH];
    assign lo         = prod_fix[WIDTH-1:0];
    assign dbz        = 1'b0;
`endif

    always_comb begin
        run_d     = run_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        q_d       = q_q;
        mcand_d   = mcand_q;
        neg_res_d = neg_res_q;
        if (start) begin
            run_d     = 1'b1;
            cnt_d     = '0;
            acc_d     = '0;
            q_d       = abs_a;
            mcand_d   = abs_b;
            neg_res_d = a[WIDTH-1] ^ b[WIDTH-1];
        end else if (run_q) begin
            acc_d = step_acc;
            q_d   = step_q;
            cnt_d = cnt_q + CntW'(1);
            if (last) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q     <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            mcand_q   <= '0;
            neg_res_q <= 1'b0;
        end else begin
            run_q     <= run_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            mcand_q   <= mcand_d;
            neg_res_q <= neg_res_d;
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// Execute-stage ALU with start/busy/done handshake; MULT/DIV use the iterative engine.
// Define ALU_DIV_EN to build the divider; otherwise DIV executes as a NOP.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = AluWidth
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alu_operation,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero
);
    localparam int unsigned ShW = $clog2(WIDTH);

    alu_op_t          op;
    logic             is_div, is_long, eng_start, eng_last, eng_dbz, alu_ovf;
    logic [WIDTH-1:0] eng_hi, eng_lo, alu_res;

    state_t           state_q, state_d;
    logic             busy_q, busy_d, done_q, done_d, zero_q, zero_d;
    logic             ovf_q, ovf_d, dbz_q, dbz_d;
    logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d, lo_q, lo_d;

    assign op = alu_op_t'(alu_operation);
`ifdef ALU_DIV_EN
    assign is_div = (op == OpDiv);
`else
    assign is_div = 1'b0;
`endif
    assign is_long   = (op == OpMult) || is_div;
    assign eng_start = (state_q == StIdle) && start && is_long;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            OpXor:  alu_res = a ^ b;
            OpOr:   alu_res = a | b;
            OpAnd:  alu_res = a & b;
            OpNor:  alu_res = ~(a | b);
            OpSll:  alu_res = a << b[ShW-1:0];
            OpSrl:  alu_res = a >> b[ShW-1:0];
            OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OpAdd: begin
                alu_res = a + b;
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OpAddu: alu_res = a + b;
            OpSub: begin
                alu_res = a - b;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OpSubu: alu_res = a - b;
            default: ;
        endcase
    end

    alu_muldiv_seq #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (eng_start),
        .is_div (is_div),
        .a      (a),
        .b      (b),
        .last   (eng_last),
        .hi     (eng_hi),
        .lo     (eng_lo),
        .dbz    (eng_dbz)
    );

    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        result_d = result_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        dbz_d    = dbz_q;
        case (state_q)
            StIdle: begin
                if (start && is_long) begin
                    state_d = StIter;
                end else if (start) begin
                    state_d  = StSingle;
                    done_d   = 1'b1;
                    result_d = alu_res;
                    zero_d   = (alu_res == '0);
                    ovf_d    = alu_ovf;
                    dbz_d    = 1'b0;
                end
            end
            StIter: begin
                // Final step: signed results are registered so they are valid with done
                if (eng_last) begin
                    state_d  = StFix;
                    done_d   = 1'b1;
                    hi_d     = eng_hi;
                    lo_d     = eng_lo;
                    result_d = eng_lo;
                    zero_d   = (eng_lo == '0);
                    ovf_d    = 1'b0;
                    dbz_d    = eng_dbz;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign zero        = zero_q;
    assign overflow    = ovf_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu: vector table, hand-written multi-cycle sequences and
// random ops against an arithmetic reference model. Honours ALU_DIV_EN like the design.
module tb_multicycle_alu;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [3:0]  alu_operation;
    logic [31:0] a, b;
    logic        busy, done, zero, overflow, div_by_zero;
    logic [31:0] result, hi, lo;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] m_res, m_hi, m_lo;
    logic        m_ovf, m_dbz;
    int          m_lat;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    multicycle_alu #(
        .WIDTH (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .alu_operation (alu_operation),
        .a             (a),
        .b             (b),
        .busy          (busy),
        .done          (done),
        .result        (result),
        .hi            (hi),
        .lo            (lo),
        .zero          (zero),
        .overflow      (overflow),
        .div_by_zero   (div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model from the operation definitions, using 64-bit signed arithmetic
    task automatic ref_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, s, p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        m_res = '0;
        m_ovf = 1'b0;
        m_dbz = 1'b0;
        m_lat = 1;
        case (op)
            4'd1: m_res = x ^ y;
            4'd2: m_res = x | y;
            4'd3: m_res = x & y;
            4'd4: m_res = ~(x | y);
            4'd5: m_res = x << y[4:0];
            4'd6: m_res = x >> y[4:0];
            4'd7: m_res = (sx < sy) ? 32'd1 : 32'd0;
            4'd8, 4'd10: begin
                s = (op == 4'd8) ? sx + sy : sx - sy;
                m_res = s[31:0];
                m_ovf = (s != longint'($signed(m_res)));
            end
            4'd9:  m_res = x + y;
            4'd11: m_res = x - y;
            4'd12: begin
                p = sx * sy;
                m_hi = p[63:32];
                m_lo = p[31:0];
                m_res = m_lo;
                m_lat = 33;
            end
            4'd13: begin
`ifdef ALU_DIV_EN
                if (y == 32'd0) begin
                    m_lo  = 32'hFFFF_FFFF;
                    m_hi  = x;
                    m_dbz = 1'b1;
                end else begin
                    s = sx / sy;
                    p = sx % sy;
                    m_lo = s[31:0];
                    m_hi = p[31:0];
                end
                m_res = m_lo;
                m_lat = 33;
`endif
            end
            default: m_res = '0;
        endcase
    endtask

    // Issue one op; operands are scrambled right after capture. Optionally pulse a stray start.
    task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                          input int restart_k, output int lat, output bit busy_ok);
        @(negedge clk);
        start = 1'b1;
        alu_operation = op;
        a = x;
        b = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        alu_operation = 4'($urandom);
        lat = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
            if (k == restart_k) begin
                start = 1'b1;
                alu_operation = 4'd8;
            end
        end
    endtask

    task automatic check_op(input string tag, input logic [3:0] op, input logic [31:0] x,
                            input logic [31:0] y);
        int lat;
        bit bok;
        ref_op(op, x, y);
        run_op(op, x, y, 0, lat, bok);
        chk({tag, ".lat"}, lat, m_lat);
        chk({tag, ".result"}, result, m_res);
        chk({tag, ".zero"}, zero, (m_res == 32'd0));
        chk({tag, ".ovf"}, overflow, m_ovf);
        chk({tag, ".hi"}, hi, m_hi);
        chk({tag, ".lo"}, lo, m_lo);
        chk({tag, ".dbz"}, div_by_zero, m_dbz);
        chk({tag, ".busy"}, bok, 1'b1);
    endtask

    initial begin
        int  lat;
        bit  bok;
        logic [3:0]  rop;
        logic [31:0] rx, ry;

        reset = 1'b1;
        start = 1'b0;
        alu_operation = 4'd0;
        a = '0;
        b = '0;
        m_hi = '0;
        m_lo = '0;

        vecs[0]  = '{4'd8,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1};
        vecs[1]  = '{4'd7,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0};
        vecs[2]  = '{4'd11, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0};
        vecs[3]  = '{4'd10, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1};
        vecs[4]  = '{4'd8,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0};
        vecs[5]  = '{4'd1,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0};
        vecs[6]  = '{4'd2,  32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0};
        vecs[7]  = '{4'd3,  32'hFFFF_0000, 32'h1234_5678, 32'h1234_0000, 1'b0};
        vecs[8]  = '{4'd4,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
        vecs[9]  = '{4'd5,  32'h0000_0001, 32'h0000_0025, 32'h0000_0020, 1'b0};
        vecs[10] = '{4'd6,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0};
        vecs[11] = '{4'd7,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        vecs[12] = '{4'd0,  32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 1'b0};
        vecs[13] = '{4'd15, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 1'b0};
        vecs[14] = '{4'd9,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst.busy", busy, 1'b0);
        chk("rst.done", done, 1'b0);
        chk("rst.result", result, 32'd0);
        chk("rst.hi", hi, 32'd0);
        chk("rst.lo", lo, 32'd0);
        chk("rst.zero", zero, 1'b1);
        chk("rst.ovf", overflow, 1'b0);
        chk("rst.dbz", div_by_zero, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, lat, bok);
            chk($sformatf("vec%0d.lat", i), lat, 1);
            chk($sformatf("vec%0d.result", i), result, vecs[i].res);
            chk($sformatf("vec%0d.ovf", i), overflow, vecs[i].ovf);
            chk($sformatf("vec%0d.zero", i), zero, (vecs[i].res == 32'd0));
            chk($sformatf("vec%0d.hi", i), hi, m_hi);
            chk($sformatf("vec%0d.lo", i), lo, m_lo);
        end

        // MULT -3 * 7 with a stray start while busy
        ref_op(4'd12, 32'hFFFF_FFFD, 32'd7);
        run_op(4'd12, 32'hFFFF_FFFD, 32'd7, 5, lat, bok);
        chk("mult.lat", lat, 33);
        chk("mult.hi", hi, 32'hFFFF_FFFF);
        chk("mult.lo", lo, 32'hFFFF_FFEB);
        chk("mult.result", result, 32'hFFFF_FFEB);
        chk("mult.busy", bok, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("mult.noqueue.done", done, 1'b0);
        chk("mult.noqueue.busy", busy, 1'b0);

`ifdef ALU_DIV_EN
        ref_op(4'd13, 32'd100, 32'hFFFF_FFF9);
        run_op(4'd13, 32'd100, 32'hFFFF_FFF9, 0, lat, bok);
        chk("div.lat", lat, 33);
        chk("div.lo", lo, 32'hFFFF_FFF2);
        chk("div.hi", hi, 32'd2);
        chk("div.dbz", div_by_zero, 1'b0);
        ref_op(4'd13, 32'd5, 32'd0);
        run_op(4'd13, 32'd5, 32'd0, 0, lat, bok);
        chk("div0.lat", lat, 33);
        chk("div0.lo", lo, 32'hFFFF_FFFF);
        chk("div0.hi", hi, 32'd5);
        chk("div0.dbz", div_by_zero, 1'b1);
`else
        ref_op(4'd13, 32'd100, 32'hFFFF_FFF9);
        run_op(4'd13, 32'd100, 32'hFFFF_FFF9, 0, lat, bok);
        chk("divnop.lat", lat, 1);
        chk("divnop.result", result, 32'd0);
        chk("divnop.zero", zero, 1'b1);
        chk("divnop.hi", hi, 32'hFFFF_FFFF);
        chk("divnop.lo", lo, 32'hFFFF_FFEB);
        chk("divnop.dbz", div_by_zero, 1'b0);
`endif
        check_op("after_div", 4'd9, 32'd1, 32'd1);

        // Reset in the middle of a MULT
        @(negedge clk);
        start = 1'b1;
        alu_operation = 4'd12;
        a = 32'h1234_5678;
        b = 32'h0000_0100;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("abort.pre.busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("abort.busy", busy, 1'b0);
        chk("abort.done", done, 1'b0);
        chk("abort.hi", hi, 32'd0);
        chk("abort.lo", lo, 32'd0);
        chk("abort.result", result, 32'd0);
        chk("abort.zero", zero, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        check_op("add2p3", 4'd8, 32'd2, 32'd3);
        chk("add2p3.const", result, 32'd5);

        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom_range(0, 15));
            rx  = $urandom;
            ry  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 2) == 0) ry = 32'($signed($urandom_range(0, 40)) - 20);
            if (i % 6 == 0) rop = 4'd12;
            if (i % 6 == 3) rop = 4'd13;
            check_op($sformatf("rand%0d", i), rop, rx, ry);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/multicycle_alu.md
# multicycle_alu

Execution unit that consumes the 4-bit `alu_operation` code produced by the ALU controller and performs the operation on two 32-bit operands. Logic, shift, compare and add/sub ops finish in one cycle. MULT and DIV run on an iterative 32-step engine that writes the HI/LO register pair. The block sits in the execute stage and uses a start/busy/done handshake, so the pipeline control logic stalls issue while a long operation is in flight.

## Interface
- `WIDTH`, 32: operand/result width; the iteration count equals WIDTH.
- `clk`  input  1  rising-edge clock
- `reset`  input  1  asynchronous, active-high reset
- `start`  input  1  request; sampled only in IDLE
- `alu_operation`  input  4  op code: NOP=0, XOR=1, OR=2, AND=3, NOR=4, SLL=5, SRL=6, SLT=7, ADD=8, ADDU=9, SUB=10, SUBU=11, MULT=12, DIV=13; 14/15 behave as NOP
- `a`, `b`  input  WIDTH each  operands, captured with `start`
- `busy`  output  1  high while state != IDLE
- `done`  output  1  one-cycle pulse; result/flags valid this cycle and held until the next `done`
- `result`  output  WIDTH  registered result; LO after MULT/DIV
- `hi`, `lo`  output  WIDTH each  HI/LO registers, written only by MULT/DIV
- `zero`  output  1  `result == 0`
- `overflow`  output  1  signed overflow for ADD/SUB; 0 for every other op
- `div_by_zero`  output  1  set by DIV with b==0, cleared by the next completed op

## Operation
- States: IDLE, SINGLE, ITER, FIX.
- IDLE + `start`, single-cycle op: compute and register `result`/flags, go to SINGLE. SINGLE asserts `done` and returns to IDLE.
- IDLE + `start`, MULT/DIV: capture |a|, |b|, sign bits and op; clear counter; go to ITER.
- ITER: one shift-add (MULT) or restoring shift-subtract (DIV) step per cycle. After step WIDTH, go to FIX.
- FIX: apply signs and write HI/LO and `result`.
  - MULT: {hi,lo} = signed 64-bit product.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the dividend's sign.
  - FIX asserts `done` and returns to IDLE.
- SLL: `a << b[4:0]`. SRL: logical `a >> b[4:0]`. SLT: signed `a<b` ? 1 : 0.
- ADD/SUB `overflow`: operand signs agree (after negating b for SUB) and the result sign differs. Result is wrapped, not trapped.
- NOP: result=0, zero=1, one-cycle latency.
- DIV with b==0: still runs full latency; lo=all-ones, hi=a, `div_by_zero`=1.
- `start` while busy: ignored, no queuing. Operands changing after capture have no effect.
- Reset mid-operation: abort immediately to IDLE; all outputs return to reset values.

## Timing
- Reset values: state IDLE, busy=0, done=0, result=0, hi=0, lo=0, zero=1, overflow=0, div_by_zero=0.
- Start sampled at edge t:
  - single-cycle op: `done` high in cycle t+1.
  - MULT/DIV: ITER at edges t+1..t+WIDTH, FIX at edge t+WIDTH+1, `done` high in cycle t+WIDTH+1 (33 cycles after the start cycle for WIDTH=32).
- `busy` rises the cycle after `start` is accepted and is high during the `done` cycle. A new `start` is accepted in the cycle after `done`.
- Back-to-back single-cycle ops: one accepted every 2 cycles.

## Configuration
- `ALU_DIV_EN` defined: DIV implemented as above.
- `ALU_DIV_EN` undefined: the divider datapath is removed. DIV behaves as NOP (result=0, one-cycle latency); hi/lo and div_by_zero are unchanged. MULT is unaffected.

## Structure
- Package `alu_pkg`: `alu_op_t` enum (4-bit codes above, shared with the ALU controller), state enum, default WIDTH constant.
- Sub-module `alu_muldiv_seq`: the iterative engine (counter, partial product/remainder registers, sign fix-up), with a start/done interface to the top FSM.

## Test plan
- ADD a=0x7FFFFFFF b=1 -> result 0x80000000, overflow=1, zero=0, done in cycle t+1.
- SLT a=0xFFFFFFFF b=1 -> result 1; SUBU a=0 b=1 -> 0xFFFFFFFF, overflow=0.
- MULT a=-3 b=7 -> hi=0xFFFFFFFF, lo=result=0xFFFFFFEB, done exactly at cycle t+33, busy high throughout; a second `start` at t+5 ignored.
- DIV a=100 b=-7 -> lo=0xFFFFFFF2, hi=2; DIV a=5 b=0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1; with `ALU_DIV_EN` undefined -> result=0, done at t+1, hi/lo unchanged.
- Assert reset at t+10 of a MULT -> busy/done/hi/lo/result=0 immediately; a subsequent ADD 2+3 -> 5 normally.
